// File: rtl/eth_rx_pkg.sv
// Shared constants and the bitwise CRC-32 step for the RMII receive stream units.
package eth_rx_pkg;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam int          AGG_DIBITS  = 16;

    // Dibit counts used by the aggregator and by the short-frame rule of the checker.
    localparam logic [4:0]  AGG_CNT_MAX    = 5'(AGG_DIBITS);
    localparam logic [4:0]  AGG_CNT_LAST   = 5'(AGG_DIBITS - 1);
    localparam logic [4:0]  CRC_MIN_DIBITS = 5'd16;

    // One reflected CRC-32 step for a single serial bit.
    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
        crc_bit = (c >> 1) ^ (((c[0] ^ b) == 1'b1) ? CRC_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/crc32_dibit.sv
// Combinational reflected CRC-32 update for one wire-order dibit (bit0 first).
module crc32_dibit
    import eth_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [1:0]  dibit,
    output logic [31:0] crc_out
);

    assign crc_out = crc_bit(crc_bit(crc_in, dibit[0]), dibit[1]);

endmodule

// File: rtl/eth_rx_stream_units.sv
// Receive post-processing: dibit bit-order fixer, 32-bit payload aggregator and
// CRC-32 frame checker, all on valid/data dibit streams without backpressure.
module eth_rx_stream_units
    import eth_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ether_axiiv,
    input  logic [1:0]  ether_axiid,
    input  logic        fw_axiiv,
    input  logic [1:0]  fw_axiid,
    output logic        bo_axiov,
    output logic [1:0]  bo_axiod,
    output logic        agg_axiov,
    output logic [31:0] agg_axiod,
    output logic        done,
    output logic        kill
);

    logic [1:0]  bo_cnt_q;
    logic [5:0]  bo_fill_q;
    logic [5:0]  bo_drain_q;
    logic [1:0]  bo_left_q;
    logic        bo_axiov_q;
    logic [1:0]  bo_axiod_q;

    // Fill buffer collects the first three dibits; the fourth hands the byte to the
    // drain buffer, which emits MSB dibit first while the next byte fills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bo_cnt_q   <= 2'd0;
            bo_fill_q  <= 6'd0;
            bo_drain_q <= 6'd0;
            bo_left_q  <= 2'd0;
            bo_axiov_q <= 1'b0;
            bo_axiod_q <= 2'd0;
        end else begin
            bo_cnt_q <= ether_axiiv ? bo_cnt_q + 2'd1 : 2'd0;
            if (ether_axiiv) begin
                case (bo_cnt_q)
                    2'd0:    bo_fill_q[1:0] <= ether_axiid;
                    2'd1:    bo_fill_q[3:2] <= ether_axiid;
                    2'd2:    bo_fill_q[5:4] <= ether_axiid;
                    default: bo_fill_q      <= bo_fill_q;
                endcase
            end
            if (ether_axiiv && bo_cnt_q == 2'd3) begin
                bo_axiod_q <= ether_axiid;
                bo_axiov_q <= 1'b1;
                bo_drain_q <= bo_fill_q;
                bo_left_q  <= 2'd3;
            end else if (bo_left_q != 2'd0) begin
                bo_axiod_q <= bo_drain_q[5:4];
                bo_axiov_q <= 1'b1;
                bo_drain_q <= {bo_drain_q[3:0], 2'b00};
                bo_left_q  <= bo_left_q - 2'd1;
            end else begin
                bo_axiod_q <= 2'd0;
                bo_axiov_q <= 1'b0;
            end
        end
    end

    logic [4:0]  agg_cnt_q;
    logic [31:0] agg_sr_q;
    logic [31:0] agg_sr_d;
    logic [31:0] agg_word_q;
    logic        agg_vld_q;

    assign agg_sr_d = {agg_sr_q[29:0], fw_axiid};

    // The shift register needs no reset: sixteen shifts always overwrite it before capture.
    always_ff @(posedge clk) begin
        if (fw_axiiv) begin
            agg_sr_q <= agg_sr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            agg_cnt_q  <= 5'd0;
            agg_word_q <= 32'd0;
            agg_vld_q  <= 1'b0;
        end else begin
            agg_vld_q <= 1'b0;
            if (!fw_axiiv) begin
                agg_cnt_q <= 5'd0;
            end else if (agg_cnt_q != AGG_CNT_MAX) begin
                agg_cnt_q <= agg_cnt_q + 5'd1;
                if (agg_cnt_q == AGG_CNT_LAST) begin
                    agg_word_q <= agg_sr_d;
                    agg_vld_q  <= 1'b1;
                end
            end
        end
    end

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [4:0]  crc_len_q;
    logic        crc_prev_v_q;
    logic        done_q;
    logic        kill_q;
    logic        frame_end;

    crc32_dibit u_crc32_dibit (
        .crc_in  (crc_q),
        .dibit   (ether_axiid),
        .crc_out (crc_d)
    );

    assign frame_end = crc_prev_v_q && !ether_axiiv;

    // Length saturates at the minimum frame size; only "short or not" matters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q        <= CRC_INIT;
            crc_len_q    <= 5'd0;
            crc_prev_v_q <= 1'b0;
            done_q       <= 1'b0;
            kill_q       <= 1'b0;
        end else begin
            crc_prev_v_q <= ether_axiiv;
            done_q       <= frame_end;
            kill_q       <= frame_end &&
                            ((crc_q != CRC_RESIDUE) || (crc_len_q != CRC_MIN_DIBITS));
            if (ether_axiiv) begin
                crc_q <= crc_d;
                if (crc_len_q != CRC_MIN_DIBITS) begin
                    crc_len_q <= crc_len_q + 5'd1;
                end
            end else begin
                crc_q     <= CRC_INIT;
                crc_len_q <= 5'd0;
            end
        end
    end

    assign bo_axiov  = bo_axiov_q;
    assign bo_axiod  = bo_axiod_q;
    assign agg_axiov = agg_vld_q;
    assign agg_axiod = agg_word_q;
    assign done      = done_q;
    assign kill      = kill_q;

endmodule

// File: tb/tb_eth_rx_stream_units.sv
// Directed bench for eth_rx_stream_units: bit-order fixer, aggregator and CRC checker.
module tb_eth_rx_stream_units;

    logic        clk;
    logic        rst;
    logic        ether_axiiv;
    logic [1:0]  ether_axiid;
    logic        fw_axiiv;
    logic [1:0]  fw_axiid;
    logic        bo_axiov;
    logic [1:0]  bo_axiod;
    logic        agg_axiov;
    logic [31:0] agg_axiod;
    logic        done;
    logic        kill;

    eth_rx_stream_units dut (
        .clk         (clk),
        .rst         (rst),
        .ether_axiiv (ether_axiiv),
        .ether_axiid (ether_axiid),
        .fw_axiiv    (fw_axiiv),
        .fw_axiid    (fw_axiid),
        .bo_axiov    (bo_axiov),
        .bo_axiod    (bo_axiod),
        .agg_axiov   (agg_axiov),
        .agg_axiod   (agg_axiod),
        .done        (done),
        .kill        (kill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    logic [1:0] bo_q[$];
    int         bo_bursts = 0;
    int         agg_pulses = 0;
    int         done_pulses = 0;
    logic       bo_prev = 1'b0;

    always @(negedge clk) begin
        if (bo_axiov) bo_q.push_back(bo_axiod);
        if (bo_axiov && !bo_prev) bo_bursts++;
        bo_prev = bo_axiov;
        if (agg_axiov) agg_pulses++;
        if (done) done_pulses++;
    end

    task automatic clr_mon();
        bo_q.delete();
        bo_bursts   = 0;
        agg_pulses  = 0;
        done_pulses = 0;
    endtask

    function automatic logic [31:0] bo_packed();
        logic [31:0] cat;
        cat = '0;
        foreach (bo_q[i]) cat = {cat[29:0], bo_q[i]};
        return cat;
    endfunction

    task automatic ether_step(input logic v, input logic [1:0] d);
        ether_axiiv = v;
        ether_axiid = d;
        @(posedge clk);
        #1;
    endtask

    task automatic fw_step(input logic v, input logic [1:0] d);
        fw_axiiv = v;
        fw_axiid = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ether_step(1'b0, 2'b00);
        end
    endtask

    logic [7:0] tx_q[$];
    logic       done_s;
    logic       kill_s;

    // Sends tx_q LSB dibit first plus npart trailing dibits, then one idle cycle,
    // capturing done/kill in the cycle after valid falls.
    task automatic send_ether(input int npart);
        logic [7:0] b;
        foreach (tx_q[i]) begin
            b = tx_q[i];
            ether_step(1'b1, b[1:0]);
            ether_step(1'b1, b[3:2]);
            ether_step(1'b1, b[5:4]);
            ether_step(1'b1, b[7:6]);
        end
        for (int k = 0; k < npart; k++) begin
            ether_step(1'b1, 2'b11);
        end
        ether_step(1'b0, 2'b00);
        done_s = done;
        kill_s = kill;
    endtask

    task automatic load_check_frame(input logic flip);
        tx_q.delete();
        for (int i = 0; i < 9; i++) tx_q.push_back(8'(8'h31 + i));
        if (flip) tx_q[0] = tx_q[0] ^ 8'h01;
        tx_q.push_back(8'h26);
        tx_q.push_back(8'h39);
        tx_q.push_back(8'hF4);
        tx_q.push_back(8'hCB);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        rst = 1'b1;
        ether_axiiv = 1'b0;
        ether_axiid = 2'b00;
        fw_axiiv = 1'b0;
        fw_axiid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bo_v",   32'(bo_axiov), 32'd0);
        check("rst_bo_d",   32'(bo_axiod), 32'd0);
        check("rst_agg_v",  32'(agg_axiov), 32'd0);
        check("rst_agg_d",  agg_axiod, 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_kill",   32'(kill), 32'd0);
        rst = 1'b0;
        idle(2);

        // Single byte 0xA5: output 10,10,01,01; a 4-dibit frame is short for the checker.
        clr_mon();
        tx_q.delete();
        tx_q.push_back(8'hA5);
        send_ether(0);
        check("a5_done", 32'(done_s), 32'd1);
        check("a5_kill", 32'(kill_s), 32'd1);
        idle(5);
        check("a5_cnt",    bo_q.size(), 32'd4);
        check("a5_dibits", bo_packed(), 32'b10_10_01_01);
        check("a5_burst",  bo_bursts, 32'd1);

        // Two bytes 0x12, 0x34: 00,01,00,10,00,11,01,00 without a gap.
        clr_mon();
        tx_q.delete();
        tx_q.push_back(8'h12);
        tx_q.push_back(8'h34);
        send_ether(0);
        idle(5);
        check("b2_cnt",    bo_q.size(), 32'd8);
        check("b2_dibits", bo_packed(), 32'b00_01_00_10_00_11_01_00);
        check("b2_burst",  bo_bursts, 32'd1);

        // Aggregator: 0xDEADBEEF MSB-first then 8 extra dibits.
        clr_mon();
        w = 32'hDEADBEEF;
        for (int k = 0; k < 24; k++) begin
            fw_step(1'b1, (k < 16) ? w[31 - 2*k -: 2] : 2'b01);
            if (k == 14) check("agg_v_d15", 32'(agg_axiov), 32'd0);
            if (k == 15) check("agg_v_d16", 32'(agg_axiov), 32'd1);
            if (k == 16) check("agg_v_d17", 32'(agg_axiov), 32'd0);
        end
        fw_step(1'b0, 2'b00);
        idle(3);
        check("agg_pulses", agg_pulses, 32'd1);
        check("agg_word",   agg_axiod, 32'hDEADBEEF);

        // Good CRC frame "123456789" + FCS.
        clr_mon();
        load_check_frame(1'b0);
        send_ether(0);
        check("crc_good_done", 32'(done_s), 32'd1);
        check("crc_good_kill", 32'(kill_s), 32'd0);
        idle(5);
        check("crc_good_bo", bo_q.size(), 32'd52);

        // One flipped payload bit.
        clr_mon();
        load_check_frame(1'b1);
        send_ether(0);
        check("crc_bad_done", 32'(done_s), 32'd1);
        check("crc_bad_kill", 32'(kill_s), 32'd1);
        idle(5);

        // Short frames: 3 bytes + 2 partial dibits on ether, 12 dibits on fw.
        clr_mon();
        tx_q.delete();
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        tx_q.push_back(8'h33);
        send_ether(2);
        check("short_done", 32'(done_s), 32'd1);
        check("short_kill", 32'(kill_s), 32'd1);
        for (int k = 0; k < 12; k++) fw_step(1'b1, 2'b10);
        fw_step(1'b0, 2'b00);
        idle(5);
        check("short_bo",      bo_q.size(), 32'd12);
        check("short_agg_p",   agg_pulses, 32'd0);
        check("short_agg_hold", agg_axiod, 32'hDEADBEEF);

        // Back-to-back good frames, one idle cycle apart.
        clr_mon();
        load_check_frame(1'b0);
        send_ether(0);
        check("b2b1_done", 32'(done_s), 32'd1);
        check("b2b1_kill", 32'(kill_s), 32'd0);
        send_ether(0);
        check("b2b2_done", 32'(done_s), 32'd1);
        check("b2b2_kill", 32'(kill_s), 32'd0);
        idle(5);
        check("b2b_pulses", done_pulses, 32'd2);
        check("b2b_bo",     bo_q.size(), 32'd104);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 5; i++) begin
            ether_step(1'b1, 2'b10);
            ether_step(1'b1, 2'b01);
            ether_step(1'b1, 2'b11);
            ether_step(1'b1, 2'b00);
        end
        check("pre_rst_bo_v", 32'(bo_axiov), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_bo_v",  32'(bo_axiov), 32'd0);
        check("mid_rst_bo_d",  32'(bo_axiod), 32'd0);
        check("mid_rst_agg_v", 32'(agg_axiov), 32'd0);
        check("mid_rst_agg_d", agg_axiod, 32'd0);
        check("mid_rst_done",  32'(done), 32'd0);
        check("mid_rst_kill",  32'(kill), 32'd0);
        ether_axiiv = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        clr_mon();
        load_check_frame(1'b0);
        send_ether(0);
        check("post_rst_done", 32'(done_s), 32'd1);
        check("post_rst_kill", 32'(kill_s), 32'd0);
        idle(5);
        check("post_rst_bo",     bo_q.size(), 32'd52);
        check("post_rst_pulses", done_pulses, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_rx_stream_units.md
# eth_rx_stream_units

Receive-side post-processing for the RMII Ethernet path. Three independent stream units sit behind the dibit deframer:
- a byte bit-order fixer on the deframer output;
- a 32-bit payload aggregator on the filtered (firewall) stream;
- a CRC-32 frame checker on the raw deframer stream.

All units use AXI-like valid/data dibit streams with no backpressure. A frame is the contiguous run of cycles with valid high.

## Interface
Parameters: none.
- clk  in  1  Ethernet clock (50 MHz RMII domain); all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- ether_axiiv  in  1  deframer valid; high for the whole frame after SFD.
- ether_axiid  in  2  deframer dibit; wire order, LSB dibit of each byte first, bit0 = earlier bit.
- fw_axiiv  in  1  firewall output valid (payload only).
- fw_axiid  in  2  firewall dibit, MSB-first order.
- bo_axiov  out  1  bit-order output valid.
- bo_axiod  out  2  bit-order output dibit, MSB-first per byte.
- agg_axiov  out  1  one-cycle pulse: 32-bit word ready.
- agg_axiod  out  32  aggregated word.
- done  out  1  one-cycle pulse at frame end.
- kill  out  1  qualified by done: 1 = FCS bad.

## Operation
Bit-order unit:
- Input byte b arrives as dibits b[1:0], b[3:2], b[5:4], b[7:6].
- Output is b[7:6], b[5:4], b[3:2], b[1:0]; each dibit is kept intact.
- Double-buffered, 4-dibit ping-pong: one buffer fills while the other drains, so back-to-back bytes stream without gaps.
- A dibit counter (0..3) resets whenever ether_axiiv is low.
- A partial byte at frame end (fewer than 4 dibits) is discarded and never output.

Aggregator:
- A dibit counter (0..16) and a 32-bit shift register, shifting left and inserting fw_axiid at [1:0].
- On the 16th valid dibit of a frame, agg_axiod = the collected word, with the first dibit at [31:30]. agg_axiov pulses once.
- Further dibits in the same frame are ignored.
- fw_axiiv low resets the counter. A frame shorter than 16 dibits produces no pulse.
- agg_axiod holds its value until the next capture.

CRC checker:
- Reflected CRC-32: polynomial 0xEDB88320, register initialised to 0xFFFFFFFF.
- Processes 2 bits per valid cycle, bit0 first, over the whole frame including the FCS.
- Register is re-initialised whenever ether_axiiv is low.
- On the falling edge of ether_axiiv (prev = 1, now = 0):
  - done = 1 for one cycle;
  - kill = (crc != 0xDEBB20E3), the good-frame residue;
  - frames with fewer than 16 dibits also set kill = 1.

## Timing
- Reset values: bo_axiov = 0, bo_axiod = 0, agg_axiov = 0, agg_axiod = 0, done = 0, kill = 0; all counters 0, CRC 0xFFFFFFFF.
- Bit-order latency: 4th dibit of a byte sampled at edge t → output dibits valid in cycles t+1..t+4. bo_axiov stays high continuously for contiguous bytes.
- Aggregator: 16th dibit sampled at edge t → agg_axiov = 1 in cycle t+1 only.
- CRC: ether_axiiv first sampled low at edge t → done/kill valid in cycle t+1.
- Back-to-back frames separated by one idle cycle must each be handled correctly.
- Async reset mid-frame: all outputs 0 immediately; the remainder of that frame is treated as a new frame once valid is seen low then high again.

## Structure
- Package eth_rx_pkg holds:
  - CRC_POLY = 32'hEDB88320;
  - CRC_INIT = 32'hFFFFFFFF;
  - CRC_RESIDUE = 32'hDEBB20E3;
  - AGG_DIBITS = 16.
- Sub-module crc32_dibit: combinational next-state function, crc_in[31:0] + dibit → crc_out. Used by the checker.
- Each of the three units is a separate always_ff group in the top, or a small sub-block.

## Test plan
- Byte 0xA5 as ether dibits 01,01,10,10 → bo_axiod 10,10,01,01 in the 4 cycles after the last input dibit.
- Frame of bytes 0x12, 0x34 → 8 contiguous bo dibits 00,01,00,10,00,11,01,00 with no gap.
- fw stream of 0xDEADBEEF MSB-first, then 8 extra dibits → agg_axiod = 0xDEADBEEF, agg_axiov high for exactly one cycle.
- Frame "123456789" (ASCII) + FCS bytes 0x26, 0x39, 0xF4, 0xCB, LSB-first dibits → done = 1, kill = 0. Flip one payload bit → done = 1, kill = 1.
- 3-byte frame (12 dibits) → no agg pulse; done = 1 with kill = 1; trailing partial byte not emitted by bo.
- Assert rst mid-frame → all outputs 0 within the same cycle; the following good frame passes normally.
